data_mem_port: RTL and testbench

- Memory-stage load/store port between the CPU MEM stage and the word-organised data RAM.
- Store path packs narrow data into word lanes: replicates bytes/halfwords and generates byte strobes.
- Load path extracts the addressed byte or halfword from the returned word, then sign- or zero-extends it to 32 bits.
- Owns a request/grant/response handshake with variable-latency memory, stalls the pipeline until the access finishes, and flags misaligned addresses.

---
 rtl/data_mem_port.sv | 206 ++++++++++++++++++++
 tb/tb_data_mem_port.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port.sv
// -----------------------------------------------------------------------------
// data_mem_port
// Load/store port between the CPU MEM stage and a word-organised data RAM.
//  - Stores: narrow data is replicated across word lanes and byte strobes are
//    generated from the size and low address bits.
//  - Loads: the addressed byte/halfword is extracted from the returned word
//    and sign- or zero-extended to 32 bits.
//  - Runs a request/grant/response handshake with variable-latency memory and
//    freezes the pipeline until the access completes. Misaligned halfword and
//    word accesses complete immediately with an address-error flag and never
//    reach memory.
//
// Ports
//  clk, rst        rising-edge clock, synchronous active-high reset
//  op_*            MEM-stage operation, held stable until done
//  stall           pipeline freeze request (combinational)
//  done            one-cycle completion pulse
//  rdata           extended load result, held until the next successful load
//  adel / ades     load / store address error, valid with done
//  mem_req/we/addr/wstrb/wdata   request side towards the RAM
//  mem_gnt         request accepted this cycle
//  mem_rvalid/rdata              read response from the RAM
// -----------------------------------------------------------------------------
module data_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              adel,
  output logic              ades,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;

  logic              misaligned;
  logic [31:0]       pack_wdata;
  logic [3:0]        pack_wstrb;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;

  // Store packing and alignment check on the incoming operation.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin : store_pack
    misaligned = 1'b0;
    pack_wdata = op_wdata;
    pack_wstrb = 4'b1111;
    case (op_size)
      2'b00: begin
        pack_wdata = {4{op_wdata[7:0]}};
        pack_wstrb = 4'b0001 << op_addr[1:0];
      end
      2'b01: begin
        misaligned = op_addr[0];
        pack_wdata = {2{op_wdata[15:0]}};
        pack_wstrb = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = |op_addr[1:0];
      end
    endcase
    // Loads never write any lane.
    if (!op_we) pack_wstrb = 4'b0000;
  end

  // Load extraction uses the size/offset latched at acceptance, since the
  // memory word arrives cycles later.
  always_comb begin : load_extract
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    adel_d  = adel_q;
    ades_d  = ades_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (misaligned) begin
            // Faulting ops skip memory entirely and finish next cycle.
            adel_d  = ~op_we;
            ades_d  = op_we;
            state_d = DONE;
          end else begin
            we_d    = op_we;
            size_d  = op_size;
            uns_d   = op_unsigned;
            off_d   = op_addr[1:0];
            addr_d  = {op_addr[ADDR_W-1:2], 2'b00};
            wdata_d = pack_wdata;
            wstrb_d = pack_wstrb;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the acceptance cycle;
  // it drops in DONE to let the stage advance.
  assign stall     = op_valid & (state_q != DONE);
  assign done      = (state_q == DONE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign adel      = adel_q;
  assign ades      = ades_q;

endmodule

// File: tb/tb_data_mem_port.sv
// -----------------------------------------------------------------------------
// tb_data_mem_port
// Self-checking bench for data_mem_port: a directed table of operations with
// hand-derived results, a reset-during-WAIT sequence, and randomized traffic
// checked against a byte-addressed reference memory model.
// -----------------------------------------------------------------------------
module tb_data_mem_port;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  data_mem_port #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_we       (op_we),
    .op_size     (op_size),
    .op_unsigned (op_unsigned),
    .op_addr     (op_addr),
    .op_wdata    (op_wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .adel        (adel),
    .ades        (ades),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;   // REQ cycles without grant before the grant
    int          rv_dly;    // cycles from grant to rvalid (>= 1)
    logic        b2b;       // issue directly in the cycle after the previous done
    logic        spur;      // precede with a stray rvalid while idle
  } op_t;

  typedef struct {
    int          lat;       // cycle of done, acceptance cycle = 0
    logic        adel;
    logic        ades;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Memory responder contents (written from the DUT's strobes) and the
  // independent reference model (written from the operation itself).
  logic [31:0] ram   [0:16383];
  logic [7:0]  ref_b [0:65535];
  logic [31:0] ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    ram[addr[15:2]] = word;
    for (int i = 0; i < 4; i++) ref_b[addr[15:0] + 16'(i)] = 8'(word >> (8 * i));
  endtask

  // Reference: alignment means the address is a multiple of the access size;
  // memory is a flat little-endian byte array.
  function automatic exp_t model_op(input op_t op);
    exp_t        e;
    int          n;
    logic [31:0] mask;
    logic [31:0] v;
    n    = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    e.adel  = 1'b0;
    e.ades  = 1'b0;
    e.strb  = 4'b0000;
    e.wdata = 32'h0;
    if ((op.addr % n) != 0) begin
      e.adel = ~op.we;
      e.ades = op.we;
      e.lat  = 1;
    end else if (op.we) begin
      e.lat   = 2 + op.gnt_dly;
      e.strb  = 4'(((1 << n) - 1) << (op.addr % 4));
      e.wdata = (op.wdata & mask) * ((n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'h1);
      for (int i = 0; i < n; i++) ref_b[op.addr[15:0] + 16'(i)] = 8'(op.wdata >> (8 * i));
    end else begin
      e.lat = 2 + op.gnt_dly + op.rv_dly;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[op.addr[15:0] + 16'(i)]) << (8 * i));
      if (!op.uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
      ref_rdata = v;
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  // One idle cycle; done/errors must be low after a completed op.
  task automatic idle_cycle();
    op_valid   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("idle done low", 32'(done), 32'h0);
    check("idle errors low", {30'h0, adel, ades}, 32'h0);
    @(posedge clk); #1;
  endtask

  // A stray rvalid while idle must change nothing.
  task automatic spur_cycle();
    op_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("spurious rvalid rdata", rdata, ref_rdata);
    check("spurious rvalid done", {31'h0, done | mem_req}, 32'h0);
    @(posedge clk); #1;
  endtask

  // Drive one operation and act as the memory; entered and left at posedge+1.
  task automatic apply(input op_t op, input exp_t ex, input string tag);
    int          cyc, req_cnt, gnt_at, done_at;
    logic        req_seen, stall_bad, hold_bad, fault, we0;
    logic        d_adel, d_ades;
    logic [31:0] a0, d0, d_rdata;
    logic [3:0]  s0;
    op_valid    = 1'b1;
    op_we       = op.we;
    op_size     = op.size;
    op_unsigned = op.uns;
    op_addr     = op.addr;
    op_wdata    = op.wdata;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    cyc = 0; req_cnt = 0; gnt_at = -1; done_at = -1;
    req_seen = 1'b0; stall_bad = 1'b0; hold_bad = 1'b0; we0 = 1'b0;
    d_adel = 1'b0; d_ades = 1'b0; d_rdata = 32'h0;
    a0 = 32'h0; d0 = 32'h0; s0 = 4'h0;
    while (done_at < 0 && cyc < 100) begin
      mem_gnt    = mem_req && (req_cnt == op.gnt_dly);
      mem_rvalid = !op.we && (gnt_at >= 0) && (cyc == gnt_at + op.rv_dly);
      mem_rdata  = mem_rvalid ? ram[a0[15:2]] : $urandom;
      @(negedge clk);
      if (stall !== !done) stall_bad = 1'b1;
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== d0 || mem_wstrb !== s0 || mem_we !== we0) begin
          hold_bad = 1'b1;
        end
        if (mem_gnt) begin
          gnt_at = cyc;
          if (mem_we)
            for (int l = 0; l < 4; l++)
              if (mem_wstrb[l]) ram[mem_addr[15:2]][8 * l +: 8] = mem_wdata[8 * l +: 8];
        end else begin
          req_cnt++;
        end
      end
      if (done) begin
        done_at = cyc; d_adel = adel; d_ades = ades; d_rdata = rdata;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    fault = ex.adel | ex.ades;
    check({tag, " done latency"}, 32'(done_at), 32'(ex.lat));
    check({tag, " adel"}, 32'(d_adel), 32'(ex.adel));
    check({tag, " ades"}, 32'(d_ades), 32'(ex.ades));
    check({tag, " rdata"}, d_rdata, ex.rdata);
    check({tag, " stall"}, 32'(stall_bad), 32'h0);
    check({tag, " mem_req issued"}, 32'(req_seen), 32'(!fault));
    if (!fault) begin
      check({tag, " mem_addr"}, a0, op.addr & 32'hFFFF_FFFC);
      check({tag, " mem_we"}, 32'(we0), 32'(op.we));
      check({tag, " mem_wstrb"}, 32'(s0), 32'(ex.strb));
      check({tag, " mem_* held"}, 32'(hold_bad), 32'h0);
      if (op.we) check({tag, " mem_wdata"}, d0, ex.wdata);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gd, input int rd, input logic b2b, input logic spur,
                              input int lat, input logic e_adel, input logic e_ades,
                              input logic [3:0] strb, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.op.we = we; v.op.size = size; v.op.uns = uns; v.op.addr = addr; v.op.wdata = wdata;
    v.op.gnt_dly = gd; v.op.rv_dly = rd; v.op.b2b = b2b; v.op.spur = spur;
    v.ex.lat = lat; v.ex.adel = e_adel; v.ex.ades = e_ades;
    v.ex.strb = strb; v.ex.wdata = ewd; v.ex.rdata = erd;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    exp_t ex;
    op_t  rop;
    //           we  sz    u   addr          wdata         gd rd b2b sp lat adel ades strb     wdata         rdata
    tbl[0]  = mk(0, 2'd0, 0, 32'h0000_1003, 32'h0,         0, 1, 0, 0, 3, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80);
    tbl[1]  = mk(0, 2'd0, 1, 32'h0000_1003, 32'h0,         0, 1, 0, 0, 3, 0, 0, 4'b0000, 32'h0,         32'h0000_0080);
    tbl[2]  = mk(1, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 3, 1, 0, 0, 5, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    tbl[3]  = mk(0, 2'd1, 0, 32'h0000_3001, 32'h0,         0, 1, 0, 0, 1, 1, 0, 4'b0000, 32'h0,         32'h0000_0080);
    tbl[4]  = mk(1, 2'd2, 0, 32'h0000_3002, 32'h5555_5555, 0, 1, 0, 0, 1, 0, 1, 4'b0000, 32'h0,         32'h0000_0080);
    tbl[5]  = mk(0, 2'd2, 0, 32'h0000_4000, 32'h0,         0, 5, 0, 1, 7, 0, 0, 4'b0000, 32'h0,         32'hDEAD_BEEF);
    tbl[6]  = mk(1, 2'd0, 0, 32'h0000_0000, 32'h1234_56A5, 0, 1, 0, 0, 2, 0, 0, 4'b0001, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    tbl[7]  = mk(0, 2'd0, 1, 32'h0000_0000, 32'h0,         0, 1, 1, 0, 3, 0, 0, 4'b0000, 32'h0,         32'h0000_00A5);
    tbl[8]  = mk(0, 2'd1, 0, 32'h0000_2002, 32'h0,         1, 2, 0, 0, 5, 0, 0, 4'b0000, 32'h0,         32'hFFFF_ABCD);
    tbl[9]  = mk(0, 2'd1, 1, 32'h0000_1002, 32'h0,         2, 1, 0, 0, 5, 0, 0, 4'b0000, 32'h0,         32'h0000_80FF);
    tbl[10] = mk(1, 2'd3, 0, 32'h0000_6000, 32'hCAFE_F00D, 0, 1, 0, 0, 2, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_80FF);
    tbl[11] = mk(0, 2'd2, 0, 32'h0000_6000, 32'h0,         0, 1, 1, 0, 3, 0, 0, 4'b0000, 32'h0,         32'hCAFE_F00D);
    tbl[12] = mk(0, 2'd0, 0, 32'h0000_2003, 32'h0,         0, 1, 0, 0, 3, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FFAB);
    tbl[13] = mk(1, 2'd1, 0, 32'h0000_2003, 32'h0000_7777, 0, 1, 0, 0, 1, 0, 1, 4'b0000, 32'h0,         32'hFFFF_FFAB);
    tbl[14] = mk(0, 2'd3, 0, 32'h0000_2001, 32'h0,         0, 1, 0, 0, 1, 1, 0, 4'b0000, 32'h0,         32'hFFFF_FFAB);

    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    for (int i = 0; i < 65536; i++) ref_b[i] = 8'h0;
    ref_rdata = 32'h0;
    preload(32'h0000_1000, 32'h80FF_1234);
    preload(32'h0000_4000, 32'hDEAD_BEEF);

    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    op_addr = 32'h0; op_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall", 32'(stall), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset adel/ades", {30'h0, adel, ades}, 32'h0);
    check("reset mem_req/we", {30'h0, mem_req, mem_we}, 32'h0);
    check("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      if (!tbl[i].op.b2b) idle_cycle();
      if (tbl[i].op.spur) spur_cycle();
      ex = model_op(tbl[i].op);
      apply(tbl[i].op, tbl[i].ex, $sformatf("vec%0d", i));
    end

    // Reset while waiting for read data; the late rvalid must be ignored.
    idle_cycle();
    op_valid = 1'b1; op_we = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h0000_4000;
    @(posedge clk); #1;
    check("rstwait mem_req in REQ", 32'(mem_req), 32'h1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rstwait mem_req in WAIT", 32'(mem_req), 32'h0);
    check("rstwait stall in WAIT", 32'(stall), 32'h1);
    rst = 1'b1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_rdata = 32'h0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rstwait done c%0d", k), 32'(done), 32'h0);
      check($sformatf("rstwait mem_req c%0d", k), 32'(mem_req), 32'h0);
      check($sformatf("rstwait rdata c%0d", k), rdata, ref_rdata);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end

    // Randomized traffic in a small window so loads hit earlier stores.
    for (int k = 0; k < 60; k++) begin
      rop.we      = 1'($urandom_range(0, 1));
      rop.size    = 2'($urandom_range(0, 3));
      rop.uns     = 1'($urandom_range(0, 1));
      rop.addr    = 32'h0000_5000 + 32'($urandom_range(0, 63));
      rop.wdata   = $urandom;
      rop.gnt_dly = $urandom_range(0, 3);
      rop.rv_dly  = $urandom_range(1, 4);
      rop.b2b     = 1'($urandom_range(0, 1));
      rop.spur    = 1'b0;
      if (!rop.b2b) idle_cycle();
      ex = model_op(rop);
      apply(rop, ex, $sformatf("rnd%0d", k));
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
